// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter unit: PC-select opcodes and
// the helper that sizes the return-stack occupancy counter.
package pc_pkg;

  localparam logic [2:0] PS_HOLD = 3'b000;
  localparam logic [2:0] PS_INC  = 3'b001;
  localparam logic [2:0] PS_BR   = 3'b010;
  localparam logic [2:0] PS_JMP  = 3'b011;
  localparam logic [2:0] PS_CALL = 3'b100;
  localparam logic [2:0] PS_RET  = 3'b101;
  localparam logic [2:0] PS_BZ   = 3'b110;
  localparam logic [2:0] PS_BN   = 3'b111;

  // Counter must represent 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/return_stack.sv
// LIFO of return addresses with a combinationally readable top entry.
// Push on full and pop on empty are ignored; the caller flags those faults.
module return_stack
  import pc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int PC_W  = 6
) (
  input  logic            clk_main,
  input  logic            reset,
  input  logic            push,
  input  logic            pop,
  input  logic [PC_W-1:0] din,
  output logic [PC_W-1:0] top,
  output logic            full,
  output logic            empty
);

  localparam int CW = cnt_w(DEPTH);

  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;
  logic            do_push;
  logic            do_pop;
  logic [PC_W-1:0] mem_q [DEPTH];

  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;

  always_comb begin
    cnt_d = cnt_q;
    if (do_push) begin
      cnt_d = cnt_q + CW'(1);
    end else if (do_pop) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Entry gi is written when it is the next free slot; contents need no reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_main) begin
      if (do_push && (cnt_q == CW'(gi))) begin
        mem_q[gi] <= din;
      end
    end
  end

  always_comb begin
    top = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt_q == CW'(i + 1)) begin
        top = mem_q[i];
      end
    end
  end

endmodule

// File: rtl/pc_stack_unit.sv
// Instruction-fetch program counter with relative/absolute/conditional
// branches, stall, and a hardware return-address stack for call/return.
module pc_stack_unit
  import pc_pkg::*;
#(
  parameter int              PC_W      = 6,
  parameter int              SEL_W     = 3,
  parameter int              DEPTH     = 4,
  parameter logic [PC_W-1:0] RESET_VEC = '0
) (
  input  logic             clk_main,
  input  logic             reset,
  input  logic [PC_W-1:0]  A,
  input  logic [SEL_W-1:0] SA,
  input  logic [SEL_W-1:0] SB,
  input  logic [2:0]       PS,
  input  logic             Z,
  input  logic             N,
  input  logic             stall,
  output logic [PC_W-1:0]  PC,
  output logic             stk_full,
  output logic             stk_empty,
  output logic             stk_err
);

  localparam int OW = 2 * SEL_W;

  logic [PC_W-1:0] pc_q;
  logic [PC_W-1:0] pc_d;
  logic            err_q;
  logic            err_d;
  logic [OW-1:0]   off_raw;
  logic [PC_W-1:0] off;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_br;
  logic [PC_W-1:0] stk_top;
  logic            push;
  logic            pop;
  logic            fault;

  assign off_raw = {SA, SB};

  if (PC_W > OW) begin : g_sext
    assign off = {{(PC_W - OW){off_raw[OW-1]}}, off_raw};
  end else begin : g_noext
    assign off = off_raw;
  end

  assign pc_inc = pc_q + PC_W'(1);
  assign pc_br  = pc_q + off;

  always_comb begin
    pc_d  = pc_q;
    push  = 1'b0;
    pop   = 1'b0;
    fault = 1'b0;
    case (PS)
      PS_HOLD: pc_d = pc_q;
      PS_INC:  pc_d = pc_inc;
      PS_BR:   pc_d = pc_br;
      PS_JMP:  pc_d = A;
      PS_CALL: begin
        // The jump is taken even when the push has nowhere to go.
        pc_d = A;
        if (stk_full) fault = 1'b1;
        else          push  = 1'b1;
      end
      PS_RET: begin
        if (stk_empty) begin
          pc_d  = pc_inc;
          fault = 1'b1;
        end else begin
          pc_d = stk_top;
          pop  = 1'b1;
        end
      end
      PS_BZ:   pc_d = Z ? pc_br : pc_inc;
      PS_BN:   pc_d = N ? pc_br : pc_inc;
      default: pc_d = pc_q;
    endcase
    if (stall) begin
      pc_d  = pc_q;
      push  = 1'b0;
      pop   = 1'b0;
      fault = 1'b0;
    end
    err_d = err_q | fault;
  end

  always_ff @(posedge clk_main) begin
    if (reset) begin
      pc_q  <= RESET_VEC;
      err_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      err_q <= err_d;
    end
  end

  return_stack #(
    .DEPTH (DEPTH),
    .PC_W  (PC_W)
  ) u_stack (
    .clk_main (clk_main),
    .reset    (reset),
    .push     (push),
    .pop      (pop),
    .din      (pc_inc),
    .top      (stk_top),
    .full     (stk_full),
    .empty    (stk_empty)
  );

  assign PC      = pc_q;
  assign stk_err = err_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboard bench: the driver pushes reference-model predictions, a monitor
// pops and compares them one cycle later against the DUT outputs.
module tb_pc_stack_unit;

  localparam int PC_W  = 6;
  localparam int SEL_W = 3;
  localparam int DEPTH = 4;
  localparam int PCM   = (1 << PC_W) - 1;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            full;
    logic            empty;
    logic            err;
  } exp_t;

  logic             clk_main = 1'b0;
  logic             reset = 1'b1;
  logic [PC_W-1:0]  A = '0;
  logic [SEL_W-1:0] SA = '0;
  logic [SEL_W-1:0] SB = '0;
  logic [2:0]       PS = 3'b000;
  logic             Z = 1'b0;
  logic             N = 1'b0;
  logic             stall = 1'b0;
  logic [PC_W-1:0]  PC;
  logic             stk_full;
  logic             stk_empty;
  logic             stk_err;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn = 0;

  int   m_pc = 0;
  int   m_stk[$];
  bit   m_err = 1'b0;

  pc_stack_unit #(
    .PC_W      (PC_W),
    .SEL_W     (SEL_W),
    .DEPTH     (DEPTH),
    .RESET_VEC ('0)
  ) dut (
    .clk_main  (clk_main),
    .reset     (reset),
    .A         (A),
    .SA        (SA),
    .SB        (SB),
    .PS        (PS),
    .Z         (Z),
    .N         (N),
    .stall     (stall),
    .PC        (PC),
    .stk_full  (stk_full),
    .stk_empty (stk_empty),
    .stk_err   (stk_err)
  );

  always #5 clk_main = ~clk_main;

  // Drive one cycle of stimulus and record what the machine should show after it.
  task automatic step(input logic r, input logic st, input logic [2:0] ps,
                      input logic [PC_W-1:0] a, input logic [SEL_W-1:0] sa,
                      input logic [SEL_W-1:0] sb, input logic z, input logic n);
    int   off;
    exp_t e;
    @(negedge clk_main);
    reset = r; stall = st; PS = ps; A = a; SA = sa; SB = sb; Z = z; N = n;
    off = int'(sa) * (1 << SEL_W) + int'(sb);
    if (off >= (1 << (2 * SEL_W - 1))) off -= (1 << (2 * SEL_W));
    if (r) begin
      m_pc = 0;
      m_stk.delete();
      m_err = 1'b0;
    end else if (!st) begin
      case (ps)
        3'd0: m_pc = m_pc;
        3'd1: m_pc = (m_pc + 1) & PCM;
        3'd2: m_pc = (m_pc + off) & PCM;
        3'd3: m_pc = int'(a);
        3'd4: begin
          if (m_stk.size() == DEPTH) m_err = 1'b1;
          else m_stk.push_back((m_pc + 1) & PCM);
          m_pc = int'(a);
        end
        3'd5: begin
          if (m_stk.size() == 0) begin
            m_err = 1'b1;
            m_pc = (m_pc + 1) & PCM;
          end else begin
            m_pc = m_stk.pop_back();
          end
        end
        3'd6: m_pc = z ? ((m_pc + off) & PCM) : ((m_pc + 1) & PCM);
        default: m_pc = n ? ((m_pc + off) & PCM) : ((m_pc + 1) & PCM);
      endcase
    end
    e.pc    = PC_W'(m_pc);
    e.full  = (m_stk.size() == DEPTH);
    e.empty = (m_stk.size() == 0);
    e.err   = m_err;
    exp_q.push_back(e);
  endtask

  task automatic op(input logic [2:0] ps, input logic [PC_W-1:0] a,
                    input logic [5:0] offv);
    step(1'b0, 1'b0, ps, a, offv[5:3], offv[2:0], 1'b0, 1'b0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk_main);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        txn++;
        checks++;
        if (PC !== e.pc || stk_full !== e.full || stk_empty !== e.empty ||
            stk_err !== e.err) begin
          errors++;
          $display("FAIL txn%0d: got PC=%0d full=%b empty=%b err=%b, want PC=%0d full=%b empty=%b err=%b",
                   txn, PC, stk_full, stk_empty, stk_err, e.pc, e.full, e.empty, e.err);
        end else begin
          $display("txn%0d ok PC=%0d full=%b empty=%b err=%b", txn, PC, stk_full,
                   stk_empty, stk_err);
        end
      end
    end
  end

  initial begin : driver
    // Reset and increment, then reset mid-run
    step(1'b1, 1'b0, 3'd1, '0, '0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 3'd1, '0, '0, '0, 1'b0, 1'b0);
    repeat (5) op(3'd1, '0, 6'd0);
    step(1'b1, 1'b1, 3'd1, '0, '0, '0, 1'b0, 1'b0);
    // Relative branch wrap
    op(3'd1, '0, 6'd0);
    op(3'd1, '0, 6'd0);
    op(3'd2, '0, 6'b111100);
    op(3'd2, '0, 6'b000011);
    // Conditional branches from PC=10
    op(3'd3, 6'd10, 6'd0);
    step(1'b0, 1'b0, 3'd6, '0, 3'd0, 3'd5, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd6, '0, 3'd0, 3'd5, 1'b1, 1'b0);
    step(1'b0, 1'b0, 3'd7, '0, 3'd7, 3'd7, 1'b0, 1'b1);
    step(1'b0, 1'b0, 3'd7, '0, 3'd7, 3'd7, 1'b1, 1'b0);
    // Nested call/return
    op(3'd3, 6'd3, 6'd0);
    op(3'd4, 6'd20, 6'd0);
    op(3'd4, 6'd40, 6'd0);
    op(3'd5, '0, 6'd0);
    op(3'd5, '0, 6'd0);
    // Overflow then underflow
    for (int i = 0; i < 5; i++) op(3'd4, PC_W'(10 + 7 * i), 6'd0);
    for (int i = 0; i < 5; i++) op(3'd5, '0, 6'd0);
    // Stall under CALL with one entry held
    step(1'b1, 1'b0, 3'd0, '0, '0, '0, 1'b0, 1'b0);
    op(3'd4, 6'd7, 6'd0);
    repeat (3) step(1'b0, 1'b1, 3'd4, 6'd30, '0, '0, 1'b0, 1'b0);
    op(3'd4, 6'd30, 6'd0);
    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
           3'($urandom_range(0, 7)), PC_W'($urandom_range(0, PCM)),
           SEL_W'($urandom_range(0, 7)), SEL_W'($urandom_range(0, 7)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end
    repeat (3) @(negedge clk_main);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d predictions left unchecked, want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program-counter unit for the datapath's instruction-fetch stage: the next generation of the 6-bit hold/increment/branch/jump counter. It adds configurable PC width and offset width, conditional branches on datapath flags, a stall input, and a hardware return-address stack for call/return. All state updates on the rising edge of `clk_main`; `PC` drives instruction-memory addressing directly.

## Interface
Parameters:
- `PC_W`, default 6: PC and jump-target width.
- `SEL_W`, default 3: width of each of `SA` and `SB`. `2*SEL_W <= PC_W` is required.
- `DEPTH`, default 4: return-stack entries, at least 1.
- `RESET_VEC`, default 0: PC value after reset.

Ports:
- `clk_main`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `A`  in  PC_W: absolute target, sourced from register-file read port A.
- `SA`  in  SEL_W: high half of the relative offset.
- `SB`  in  SEL_W: low half of the relative offset.
- `PS`  in  3: PC select opcode.
- `Z`  in  1: datapath zero flag.
- `N`  in  1: datapath negative flag.
- `stall`  in  1: freezes all state when high.
- `PC`  out  PC_W: current program counter.
- `stk_full`  out  1: high when the stack holds DEPTH entries.
- `stk_empty`  out  1: high when the stack holds 0 entries.
- `stk_err`  out  1: sticky flag for stack overflow or underflow.

## Operation
- Offset: `off` = sign-extension of {SA,SB} (2*SEL_W bits) to PC_W. All PC arithmetic is modulo 2^PC_W; wrap-around is silent.
- PS encodings:
  - 000 HOLD: PC unchanged.
  - 001 INC: PC+1.
  - 010 BR: PC+off.
  - 011 JMP: A.
  - 100 CALL: push PC+1, then PC ← A.
  - 101 RET: PC ← top of stack, then pop.
  - 110 BZ: PC+off if Z, else PC+1.
  - 111 BN: PC+off if N, else PC+1.
- Stack is a LIFO with count 0..DEPTH. The top entry is readable combinationally for RET.
- CALL when full: the jump to A still occurs. The push is suppressed, the stack is unchanged, and `stk_err` is set.
- RET when empty: PC ← PC+1, the count stays 0, and `stk_err` is set.
- Only one stack operation can occur per cycle; no simultaneous push and pop exists.
- `stall`=1: PC, the stack, the count and `stk_err` all hold. PS is ignored. `reset` overrides `stall`.
- `stk_err` is sticky until reset.
- Reset, including mid-operation: PC=RESET_VEC, count=0, `stk_empty`=1, `stk_full`=0, `stk_err`=0. Stack contents are don't-care.

## Timing
- Single-cycle: the new PC is visible one edge after PS, A, SA, SB, Z and N are sampled.
- `stk_full` and `stk_empty` are decoded from the registered count, so they are valid in the cycle after the edge that changed it.
- `stk_err` rises on the edge that performs the faulting CALL or RET.
- No combinational path from any input to `PC` or to the flags.
- The stage supplying Z and N must hold them stable for the full cycle that PS=110/111 is presented.

## Structure
- Shared package `pc_pkg`:
  - localparams for the PS encodings: `PS_HOLD`, `PS_INC`, `PS_BR`, `PS_JMP`, `PS_CALL`, `PS_RET`, `PS_BZ`, `PS_BN`.
  - the count-width helper `$clog2(DEPTH+1)`.
- One sub-module, `return_stack`:
  - parameters DEPTH and PC_W.
  - inputs `push`, `pop`, `din`.
  - outputs `top`, `full`, `empty`.
  - it is synchronous-reset and has no knowledge of PS.
- The top level computes next-PC and the push/pop qualifiers, and owns the `stk_err` register.

## Test plan
- Reset and increment: reset high for 2 edges → PC=0. Then 5 edges of INC → PC=5. Reset asserted mid-run → PC=0 on the next edge.
- Relative branch wrap, defaults: PC=2, BR with {SA,SB}=6'b111100 (-4) → PC=62. Next, BR with +3 (000011) → PC=1.
- Conditional branches: at PC=10, BZ with Z=0 and offset 5 → PC=11. BZ with Z=1 and offset 5 → PC=16. BN with N=1 and offset -1 → PC=15.
- Call/return nesting: from PC=3, CALL A=20, then CALL A=40, then RET → PC=21, then RET → PC=4. `stk_empty` ends at 1 and `stk_err` stays 0.
- Overflow/underflow, DEPTH=4:
  - 5 consecutive CALLs → `stk_full`=1 after the 4th, and `stk_err`=1 after the 5th. PC equals the 5th target.
  - 4 RETs then return in LIFO order; a 5th RET → PC+1 and `stk_err` stays 1.
- Stall: PC=7 with one stack entry and `stall`=1 for 3 edges under PS=CALL → PC=7 and count unchanged. Releasing the stall → CALL executes on the next edge.
